// File: rtl/morse_pkg.sv
// morse_pkg: shared state encoding and sizing constants for the Morse round scheduler.
package morse_pkg;
  localparam int DIGIT_W = 4;
  localparam int NUM_SLOTS = 3;
  localparam int BCD_MAX = 9;
  typedef enum logic [1:0] {IDLE, SHOW, WAIT_IN, DONE} state_t;
endpackage

// File: rtl/bcd_score_counter.sv
// bcd_score_counter: two-digit BCD score with clear, add-by-N (N<=3) and saturation at 99.
module bcd_score_counter
  import morse_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic [1:0]         inc,
  output logic [DIGIT_W-1:0] ones,
  output logic [DIGIT_W-1:0] tens
);
  localparam logic [7:0] MAX = 8'(BCD_MAX * 10 + BCD_MAX);
  logic [7:0] sum, sat;
  always_comb begin
    sum = 8'(tens) * 8'd10 + 8'(ones) + 8'(inc);
    sat = sum > MAX ? MAX : sum;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ones <= '0;
      tens <= '0;
    end else if (clear) begin
      ones <= '0;
      tens <= '0;
    end else if (inc != 2'd0) begin
      ones <= DIGIT_W'(sat % 8'd10);
      tens <= DIGIT_W'(sat / 8'd10);
    end
  end
endmodule

// File: rtl/morse_round_scheduler.sv
// morse_round_scheduler: shows three random digits, then scores the user's entries in BCD.
// Define MORSE_ROUND_BONUS_EN to award +2 for a round with all three entries correct.
module morse_round_scheduler
  import morse_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int SHOW_SEC      = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               logged_in,
  input  logic               start,
  input  logic [DIGIT_W-1:0] digit_in,
  input  logic               load,
  input  logic [DIGIT_W-1:0] user_input,
  input  logic               timeout,
  input  logic               logout,
  output logic [DIGIT_W-1:0] number,
  output logic               show,
  output logic               reconfig,
  output logic               enable,
  output logic [DIGIT_W-1:0] score_ones,
  output logic [DIGIT_W-1:0] score_tens,
  output logic               correct,
  output logic               logout_done,
  output logic               busy
);
  localparam int SLOT_CYC = TICKS_PER_SEC * SHOW_SEC;
  localparam int CW = $clog2(SLOT_CYC + 1);
  localparam logic [1:0] LAST = 2'(NUM_SLOTS - 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [1:0] k, j, inc;
  logic [DIGIT_W-1:0] slot [NUM_SLOTS];
  logic hit;
  assign hit = state == WAIT_IN && load && !logout && user_input == slot[j];
  assign show = state == SHOW;
  assign enable = state == WAIT_IN;
  assign busy = state != IDLE;
`ifdef MORSE_ROUND_BONUS_EN
  logic [1:0] hits;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) hits <= '0;
    else if (logout || state == SHOW) hits <= '0;
    else if (hit) hits <= hits + 2'd1;
  end
  assign inc = hit ? 2'd1 : (state == DONE && hits == 2'd3) ? 2'd2 : 2'd0;
`else
  assign inc = {1'b0, hit};
`endif
  bcd_score_counter u_score (
    .clk  (clk),
    .rst  (rst),
    .clear(logout),
    .inc  (inc),
    .ones (score_ones),
    .tens (score_tens)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      k <= '0;
      j <= '0;
      number <= '0;
      reconfig <= 1'b0;
      correct <= 1'b0;
      logout_done <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) slot[i] <= '0;
    end else begin
      reconfig <= 1'b0;
      correct <= 1'b0;
      logout_done <= 1'b0;
      if (logout) begin
        state <= IDLE;
        cnt <= '0;
        k <= '0;
        j <= '0;
        number <= '0;
        logout_done <= 1'b1;
      end else begin
        case (state)
          IDLE: if (start && logged_in) begin
            state <= SHOW;
            cnt <= '0;
            k <= '0;
            slot[0] <= digit_in;
            number <= digit_in;
          end
          SHOW: if (cnt == CW'(SLOT_CYC - 1)) begin
            cnt <= '0;
            if (k == LAST) begin
              state <= WAIT_IN;
              number <= '0;
              reconfig <= 1'b1;
              j <= '0;
            end else begin
              k <= k + 2'd1;
              slot[k + 2'd1] <= digit_in;
              number <= digit_in;
            end
          end else cnt <= cnt + CW'(1);
          WAIT_IN: begin
            if (load) begin
              correct <= hit;
              j <= j + 2'd1;
            end
            // a load coinciding with timeout is scored above before leaving
            if (timeout || (load && j == LAST)) state <= DONE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_morse_round_scheduler.sv
// tb_morse_round_scheduler: directed checks of the round scheduler with 12-cycle display slots.
module tb_morse_round_scheduler;
  localparam int TPS = 4;
  localparam int SS = 3;
  localparam int SLOT = TPS * SS;
`ifdef MORSE_ROUND_BONUS_EN
  localparam bit BONUS = 1'b1;
`else
  localparam bit BONUS = 1'b0;
`endif
  localparam int FULL = BONUS ? 5 : 3;
  logic clk = 1'b0, rst = 1'b0, logged_in = 1'b0, start = 1'b0, load = 1'b0, timeout = 1'b0, logout = 1'b0;
  logic [3:0] digit_in = '0, user_input = '0;
  logic [3:0] number, score_ones, score_tens;
  logic show, reconfig, enable, correct, logout_done, busy;
  logic [7:0] score;
  int n_cmp = 0, n_bad = 0, exp_score = 0;
  assign score = {score_tens, score_ones};
  always #5 clk = ~clk;
  morse_round_scheduler #(.TICKS_PER_SEC(TPS), .SHOW_SEC(SS)) dut (
    .clk(clk), .rst(rst), .logged_in(logged_in), .start(start), .digit_in(digit_in),
    .load(load), .user_input(user_input), .timeout(timeout), .logout(logout),
    .number(number), .show(show), .reconfig(reconfig), .enable(enable),
    .score_ones(score_ones), .score_tens(score_tens), .correct(correct),
    .logout_done(logout_done), .busy(busy)
  );
  function automatic int sat(input int v);
    return v > 99 ? 99 : v;
  endfunction
  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic to_wait(input logic [11:0] d);
    digit_in = d[3:0];
    logged_in = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int s = 0; s < 3; s++) begin
      digit_in = d[4*((s+1)%3) +: 4];
      for (int c = 0; c < SLOT; c++) begin
        chk("number", 8'(number), 8'(d[4*s +: 4]));
        chk("show", 8'(show), 8'd1);
        tick;
      end
    end
    chk("reconfig", 8'(reconfig), 8'd1);
    chk("enable", 8'(enable), 8'd1);
    chk("show_off", 8'(show), 8'd0);
    tick;
    chk("reconfig_pulse", 8'(reconfig), 8'd0);
    chk("enable_hold", 8'(enable), 8'd1);
  endtask
  task automatic play(input logic [11:0] d, input int n, input logic [11:0] u, input bit to);
    int hits;
    logic h;
    hits = 0;
    to_wait(d);
    for (int i = 0; i < n; i++) begin
      load = 1'b1;
      user_input = u[4*i +: 4];
      timeout = to && i == n - 1;
      tick;
      load = 1'b0;
      timeout = 1'b0;
      h = u[4*i +: 4] == d[4*i +: 4];
      hits += int'(h);
      exp_score = sat(exp_score + int'(h));
      chk("correct", 8'(correct), 8'(h));
      chk("score", score, bcd(exp_score));
    end
    if (n < 3 && !to) begin
      chk("enable_wait", 8'(enable), 8'd1);
      timeout = 1'b1;
      tick;
      timeout = 1'b0;
    end
    chk("done_busy", 8'(busy), 8'd1);
    chk("done_enable", 8'(enable), 8'd0);
    tick;
    if (BONUS && hits == 3) exp_score = sat(exp_score + 2);
    chk("idle_busy", 8'(busy), 8'd0);
    chk("idle_correct", 8'(correct), 8'd0);
    chk("score_held", score, bcd(exp_score));
  endtask
  initial begin
    #1;
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_number", 8'(number), 8'd0);
    chk("rst_score", score, 8'h00);
    #12 rst = 1'b1;
    tick;
    tick;
    chk("post_rst_busy", 8'(busy), 8'd0);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("start_logged_out", 8'(busy), 8'd0);
    play(12'h275, 3, 12'h275, 1'b0);
    play(12'h275, 2, 12'h095, 1'b0);
    chk("round_b_score", score, BONUS ? 8'h06 : 8'h04);
    digit_in = 4'd4;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (5) tick;
    chk("show_busy", 8'(busy), 8'd1);
    logout = 1'b1;
    tick;
    logout = 1'b0;
    exp_score = 0;
    chk("logout_busy", 8'(busy), 8'd0);
    chk("logout_done", 8'(logout_done), 8'd1);
    chk("logout_score", score, 8'h00);
    chk("logout_number", 8'(number), 8'd0);
    chk("logout_show", 8'(show), 8'd0);
    tick;
    chk("logout_done_pulse", 8'(logout_done), 8'd0);
    logged_in = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("logged_out_start", 8'(busy), 8'd0);
    while (exp_score < 98) begin
      if (98 - exp_score >= FULL) play(12'h318, 3, 12'h318, 1'b0);
      else play(12'h318, 1, 12'h008, 1'b1);
    end
    chk("score_98", score, 8'h98);
    play(12'h964, 3, 12'h964, 1'b0);
    chk("score_sat", score, 8'h99);
    to_wait(12'h123);
    load = 1'b1;
    user_input = 4'd3;
    tick;
    load = 1'b0;
    chk("pre_rst_correct", 8'(correct), 8'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", 8'(busy), 8'd0);
    chk("arst_enable", 8'(enable), 8'd0);
    chk("arst_correct", 8'(correct), 8'd0);
    chk("arst_score", score, 8'h00);
    chk("arst_number", 8'(number), 8'd0);
    #3 rst = 1'b1;
    tick;
    tick;
    chk("release_busy", 8'(busy), 8'd0);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("fresh_start_busy", 8'(busy), 8'd1);
    chk("fresh_start_number", 8'(number), 8'd3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/morse_round_scheduler.md
MORSE_ROUND_SCHEDULER -- requirements
Module: morse_round_scheduler

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 50000000, meaning clock cycles per second.
REQ-002 SHALL have parameter SHOW_SEC, default 3, meaning seconds each digit is displayed.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port logged_in, input, 1, hard-mode user is logged in.
REQ-006 SHALL have port start, input, 1, one-cycle round-start request.
REQ-007 SHALL have port digit_in, input, 4, free-running random digit source.
REQ-008 SHALL have port load, input, 1, one-cycle user-entry strobe.
REQ-009 SHALL have port user_input, input, 4, user-entered digit.
REQ-010 SHALL have port timeout, input, 1, input-window expiry from the external window timer.
REQ-011 SHALL have port logout, input, 1, logout request.
REQ-012 SHALL have outputs: number (4b, digit shown), show (1b, display valid), reconfig (1b, window-open pulse), enable (1b, input window open), score_ones and score_tens (4b each, BCD score), correct (1b, match pulse), logout_done (1b, pulse), busy (1b, not IDLE).

Function
REQ-013 SHALL implement states IDLE, SHOW, WAIT_IN and DONE.
REQ-014 IDLE -> SHOW SHALL occur only on start=1 with logged_in=1; start is ignored when logged_in=0 and in any state other than IDLE.
REQ-015 On entry to each of three SHOW slots (k=0..2), digit_in SHALL be latched into slot[k] and driven on number with show=1.
REQ-016 Each slot SHALL last exactly SHOW_SEC*TICKS_PER_SEC cycles; after slot 2, the next state SHALL be WAIT_IN.
REQ-017 On WAIT_IN entry, reconfig SHALL pulse for 1 cycle, enable SHALL be 1 throughout WAIT_IN, show SHALL be 0, and entry index j=0.
REQ-018 In WAIT_IN, load SHALL compare user_input against slot[j]; on a match, correct SHALL pulse 1 cycle later and the score SHALL increment by 1 in that same cycle; j SHALL increment regardless of match.
REQ-019 WAIT_IN -> DONE SHALL occur after the third load or on timeout; with load and timeout in the same cycle, the load is scored first, then the state exits.
REQ-020 DONE SHALL last 1 cycle and then go to IDLE; the score is held across rounds.
REQ-021 The score SHALL be 2-digit BCD that saturates at 99 with no wrap.
REQ-022 logout SHALL have priority in every state: next state IDLE, score cleared to 00, logout_done pulsed for 1 cycle, and all other outputs set to 0.

Reset
REQ-023 While rst=0, state SHALL be IDLE and every output, slot, counter and score SHALL be 0, asynchronously.
REQ-024 Release of rst SHALL NOT start a round; a round requires a fresh start.

Configuration
REQ-025 With MORSE_ROUND_BONUS_EN defined, a round with all three entries correct SHALL add +2 extra points in the DONE cycle, saturating at 99.
REQ-026 Without MORSE_ROUND_BONUS_EN, no bonus logic SHALL exist and the score SHALL change only per REQ-018.

Structure
REQ-027 Package morse_pkg SHALL hold the state enum, DIGIT_W=4, NUM_SLOTS=3 and the BCD max constant 9.
REQ-028 Sub-module bcd_score_counter SHALL provide clear, increment-by-N (N<=3) and saturation; there SHALL be no other sub-module.

Verification
REQ-029 With TICKS_PER_SEC=4, SHOW_SEC=3, logged_in=1 and start pulsed with digit_in=5,7,2 at slot starts -> number is 5, 7, 2 for 12 cycles each, then a reconfig pulse and enable=1.
REQ-030 Loads 5, 7, 2 -> three correct pulses and score 03; with MORSE_ROUND_BONUS_EN the score is 05.
REQ-031 Loads 5 and 9, then timeout -> a single correct pulse, score 01, DONE, then IDLE.
REQ-032 Preload score 98 and make three correct entries -> score saturates at 99.
REQ-033 logout mid-SHOW -> IDLE next cycle, score 00, one-cycle logout_done; start with logged_in=0 -> busy remains 0.
REQ-034 rst low mid-WAIT_IN -> all outputs 0 immediately; after release, busy remains 0 until start.
